// File: rtl/fwd_buf.sv
// fwd_buf: forward-path pipeline buffer for a valid/ready stream.
//
// Data and valid pass through STAGES bubble-collapsing register stages.
// Ready propagates combinationally from output_port_ready back to
// input_port_ready, so this cuts data/valid paths but not the ready path.
//
// Optional feature: define FWD_BUF_OCCUPANCY_EN to add the occupancy port.
//
// Parameters:
//   WIDTH   payload width in bits (>= 1)
//   STAGES  number of register stages (>= 1); forward latency
// Ports:
//   clock_port         clock, rising edge
//   reset_port         asynchronous active-high reset (empties all stages, zeroes data)
//   clear              synchronous flush; blocks transfers during its cycle
//   input_port_data    upstream payload
//   input_port_valid   upstream valid
//   input_port_ready   buffer can accept a beat this cycle
//   output_port_data   downstream payload (last stage register)
//   output_port_valid  last stage holds a beat
//   output_port_ready  downstream accepts
//   occupancy          number of valid stages (FWD_BUF_OCCUPANCY_EN only)
module fwd_buf #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic                          clock_port,
  input  logic                          reset_port,
  input  logic                          clear,
  input  logic [WIDTH-1:0]              input_port_data,
  input  logic                          input_port_valid,
  output logic                          input_port_ready,
  output logic [WIDTH-1:0]              output_port_data,
  output logic                          output_port_valid,
  input  logic                          output_port_ready
`ifdef FWD_BUF_OCCUPANCY_EN
  ,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
`endif
);

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] data_q,  data_d;

  // ready[k] for stage k; ready[STAGES] is the downstream ready.
  logic [STAGES:0]              ready;
  logic                         tail_full;
  logic [STAGES-1:0]            up_valid;
  logic [STAGES-1:0][WIDTH-1:0] up_data;

  // ready_k = ~valid_k | ready_{k+1} is unrolled as
  // output_port_ready | ~&valid[STAGES-1:k] so that no vector bit
  // feeds another bit of the same vector.
  always_comb begin
    ready         = '0;
    tail_full     = 1'b1;
    ready[STAGES] = output_port_ready;
    for (int unsigned i = STAGES; i > 0; i--) begin
      tail_full  = tail_full & valid_q[i-1];
      ready[i-1] = output_port_ready | ~tail_full;
    end
  end

  // Upstream view for every stage: port for stage 0, previous stage otherwise.
  always_comb begin
    up_valid    = '0;
    up_data     = '0;
    up_valid[0] = input_port_valid & ~clear;
    up_data[0]  = input_port_data;
    for (int unsigned k = 1; k < STAGES; k++) begin
      up_valid[k] = valid_q[k-1];
      up_data[k]  = data_q[k-1];
    end
  end

  // Data is written only when a real beat moves in, and never under clear,
  // so flushed registers keep their contents.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (clear) begin
        valid_d[k] = 1'b0;
      end else if (ready[k]) begin
        valid_d[k] = up_valid[k];
        if (up_valid[k]) begin
          data_d[k] = up_data[k];
        end
      end
    end
  end

  always_ff @(posedge clock_port or posedge reset_port) begin
    if (reset_port) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign input_port_ready  = ready[0] & ~clear;
  assign output_port_valid = valid_q[STAGES-1] & ~clear;
  assign output_port_data  = data_q[STAGES-1];

`ifdef FWD_BUF_OCCUPANCY_EN
  logic [$clog2(STAGES+1)-1:0] occ_cnt;

  // Register state only; not masked by clear.
  always_comb begin
    occ_cnt = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occ_cnt = occ_cnt + ($clog2(STAGES+1))'(valid_q[k]);
    end
    occupancy = reset_port ? '0 : occ_cnt;
  end
`endif

endmodule

// File: tb/tb_fwd_buf.sv
module tb_fwd_buf;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // STAGES=2 instance (directed tests)
  logic [7:0] id2, od2;
  logic       iv2, ir2, ov2, or2;
  // STAGES=1 and STAGES=3 instances (random scoreboard)
  logic [7:0] id1, od1, id3, od3;
  logic       iv1, ir1, ov1, or1;
  logic       iv3, ir3, ov3, or3;
`ifdef FWD_BUF_OCCUPANCY_EN
  logic [1:0] occ2;
  logic [0:0] occ1;
  logic [1:0] occ3;
`endif

  fwd_buf #(.WIDTH(8), .STAGES(2)) u_s2 (
    .clock_port(clk), .reset_port(rst), .clear(clr),
    .input_port_data(id2), .input_port_valid(iv2), .input_port_ready(ir2),
    .output_port_data(od2), .output_port_valid(ov2), .output_port_ready(or2)
`ifdef FWD_BUF_OCCUPANCY_EN
    , .occupancy(occ2)
`endif
  );

  fwd_buf #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clock_port(clk), .reset_port(rst), .clear(clr),
    .input_port_data(id1), .input_port_valid(iv1), .input_port_ready(ir1),
    .output_port_data(od1), .output_port_valid(ov1), .output_port_ready(or1)
`ifdef FWD_BUF_OCCUPANCY_EN
    , .occupancy(occ1)
`endif
  );

  fwd_buf #(.WIDTH(8), .STAGES(3)) u_s3 (
    .clock_port(clk), .reset_port(rst), .clear(clr),
    .input_port_data(id3), .input_port_valid(iv3), .input_port_ready(ir3),
    .output_port_data(od3), .output_port_valid(ov3), .output_port_ready(or3)
`ifdef FWD_BUF_OCCUPANCY_EN
    , .occupancy(occ3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ2(input string tag, input int exp);
`ifdef FWD_BUF_OCCUPANCY_EN
    chk(tag, 32'(occ2), 32'(exp));
`endif
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q1[$];
  logic [7:0] q3[$];
  int sent1 = 0, recv1 = 0, sent3 = 0, recv3 = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    iv2 = 1'b0; id2 = '0; or2 = 1'b0;
    iv1 = 1'b0; id1 = '0; or1 = 1'b0;
    iv3 = 1'b0; id3 = '0; or3 = 1'b0;
    #2;
    chk("reset_ovalid", ov2, 0);
    chk("reset_odata", od2, 0);
    chk("reset_iready", ir2, 1);
    chk_occ2("reset_occ", 0);
    @(negedge clk);
    rst = 1'b0;
    tick;

    // Streaming 0x01..0x10, downstream always ready
    or2 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      iv2 = 1'b1; id2 = 8'(i);
      #1;
      chk("stream_iready", ir2, 1);
      chk("stream_ovalid", ov2, 32'(i >= 3));
      if (i >= 3) chk("stream_data", od2, 32'(i - 2));
      tick;
    end
    iv2 = 1'b0;
    #1;
    chk("stream_tail15_v", ov2, 1);
    chk("stream_tail15_d", od2, 8'h0F);
    tick;
    chk("stream_tail16_v", ov2, 1);
    chk("stream_tail16_d", od2, 8'h10);
    tick;
    chk("stream_empty", ov2, 0);

    // Backpressure
    or2 = 1'b0;
    iv2 = 1'b1; id2 = 8'hA0;
    #1;
    chk("bp_a0_iready", ir2, 1);
    tick;
    id2 = 8'hA1;
    #1;
    chk("bp_a1_iready", ir2, 1);
    chk("bp_a1_ovalid", ov2, 0);
    tick;
    id2 = 8'hA2;
    #1;
    chk("bp_full_iready", ir2, 0);
    chk("bp_full_ovalid", ov2, 1);
    chk("bp_full_odata", od2, 8'hA0);
    chk_occ2("bp_full_occ", 2);
    tick;
    chk("bp_hold_iready", ir2, 0);
    chk("bp_hold_odata", od2, 8'hA0);
    or2 = 1'b1;
    #1;
    chk("bp_release_iready", ir2, 1);
    chk("bp_release_odata", od2, 8'hA0);
    chk_occ2("bp_release_occ", 2);
    tick;
    iv2 = 1'b0;
    #1;
    chk("bp_out_a1_v", ov2, 1);
    chk("bp_out_a1_d", od2, 8'hA1);
    chk_occ2("bp_inout_occ", 2);
    tick;
    chk("bp_out_a2_v", ov2, 1);
    chk("bp_out_a2_d", od2, 8'hA2);
    tick;
    chk("bp_drained", ov2, 0);

    // Bubble collapse: 0x55 stalled in last stage, stage 0 empty
    or2 = 1'b0;
    iv2 = 1'b1; id2 = 8'h55;
    #1;
    tick;
    iv2 = 1'b0;
    #1;
    tick;
    chk("bub_ovalid", ov2, 1);
    chk("bub_odata", od2, 8'h55);
    chk("bub_iready", ir2, 1);
    chk_occ2("bub_occ1", 1);
    iv2 = 1'b1; id2 = 8'h66;
    #1;
    chk("bub_accept_iready", ir2, 1);
    tick;
    iv2 = 1'b0;
    #1;
    chk("bub_full_iready", ir2, 0);
    chk("bub_full_odata", od2, 8'h55);
    chk_occ2("bub_occ2", 2);

    // Clear with a full buffer and a pending input beat
    clr = 1'b1; iv2 = 1'b1; id2 = 8'h33; or2 = 1'b1;
    #1;
    chk("clr_iready", ir2, 0);
    chk("clr_ovalid", ov2, 0);
    chk_occ2("clr_occ_unmasked", 2);
    tick;
    clr = 1'b0; iv2 = 1'b0;
    #1;
    chk("clr_after_ovalid", ov2, 0);
    chk("clr_after_iready", ir2, 1);
    chk("clr_data_kept", od2, 8'h55);
    chk_occ2("clr_after_occ", 0);
    tick;
    chk("clr_33_dropped", ov2, 0);
    tick;
    chk("clr_33_dropped2", ov2, 0);

    // Asynchronous reset mid-cycle with two beats buffered
    or2 = 1'b0;
    iv2 = 1'b1; id2 = 8'h77;
    #1;
    tick;
    id2 = 8'h88;
    #1;
    tick;
    iv2 = 1'b0;
    #1;
    chk("rst_pre_ovalid", ov2, 1);
    chk("rst_pre_odata", od2, 8'h77);
    chk("rst_pre_iready", ir2, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_ovalid", ov2, 0);
    chk("rst_async_odata", od2, 0);
    chk("rst_async_iready", ir2, 1);
    chk_occ2("rst_async_occ", 0);
    #2 rst = 1'b0;
    tick;
    iv2 = 1'b1; id2 = 8'h99; or2 = 1'b1;
    #1;
    chk("post_rst_no_stale", ov2, 0);
    chk("post_rst_iready", ir2, 1);
    tick;
    iv2 = 1'b0;
    #1;
    chk("post_rst_lat", ov2, 0);
    tick;
    chk("post_rst_first_v", ov2, 1);
    chk("post_rst_first_d", od2, 8'h99);
    tick;
    chk("post_rst_empty", ov2, 0);

    // Random valid/ready on STAGES=1 and STAGES=3
    for (int cyc = 0; cyc < 20000 && (recv1 < 1000 || recv3 < 1000); cyc++) begin
      iv1 = (sent1 < 1000) && ($urandom_range(0, 3) != 0);
      id1 = 8'($urandom);
      or1 = ($urandom_range(0, 2) != 0);
      iv3 = (sent3 < 1000) && ($urandom_range(0, 3) != 0);
      id3 = 8'($urandom);
      or3 = ($urandom_range(0, 2) != 0);
      #1;
      if (iv1 && ir1) begin q1.push_back(id1); sent1++; end
      if (iv3 && ir3) begin q3.push_back(id3); sent3++; end
      if (ov1 && or1) begin
        if (q1.size() == 0) chk("rand_s1_extra", ov1, 0);
        else begin chk("rand_s1_data", od1, q1.pop_front()); recv1++; end
      end
      if (ov3 && or3) begin
        if (q3.size() == 0) chk("rand_s3_extra", ov3, 0);
        else begin chk("rand_s3_data", od3, q3.pop_front()); recv3++; end
      end
      tick;
    end
    iv1 = 1'b0; iv3 = 1'b0;
    chk("rand_s1_count", recv1, 1000);
    chk("rand_s3_count", recv3, 1000);
    chk("rand_s1_left", q1.size(), 0);
    chk("rand_s3_left", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
